// File: rtl/fetch_predict_stage_if.sv
// Fetch-stage bus: icache read side, hazard/flush controls, BTB training port and
// the registered fetch/decode record (imemload, NPC, PC, branch_taken, pred_branch_addr).
interface fetch_predict_stage_if;
    logic         ihit;
    logic [31:0]  imemload;
    logic         iREN;
    logic [31:0]  imemaddr;
    logic         stall;
    logic         flush;
    logic [31:0]  correct_pc;
    logic         update_en;
    logic [31:0]  update_pc;
    logic [31:0]  update_target;
    logic         update_taken;
    logic         halt;
    logic [128:0] fetch_out;

    modport master (
        output ihit, imemload, stall, flush, correct_pc,
               update_en, update_pc, update_target, update_taken, halt,
        input  iREN, imemaddr, fetch_out
    );

    modport slave (
        input  ihit, imemload, stall, flush, correct_pc,
               update_en, update_pc, update_target, update_taken, halt,
        output iREN, imemaddr, fetch_out
    );
endinterface

// File: rtl/fetch_predict_stage.sv
// Instruction fetch with a direct-mapped BTB of 2-bit saturating counters; owns the PC,
// predicts the next PC, and is trained by resolved branches from execute.
module fetch_predict_stage #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] PC_INIT     = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  nRST,
    fetch_predict_stage_if.slave  bus
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic            ent_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] ent_tag    [BTB_ENTRIES];
    logic [31:0]     ent_target [BTB_ENTRIES];
    logic [1:0]      ent_ctr    [BTB_ENTRIES];

    logic [31:0]  pc_q, pc_d;
    logic [128:0] fetch_q, fetch_d;
    logic         halted_q, halted_d;

    logic [IDX-1:0]  lk_idx, up_idx;
    logic [TAGW-1:0] lk_tag, up_tag;
    logic            lk_hit, up_hit, pred_taken;
    logic [31:0]     pred_target, pc_plus4;
    logic            unused_up_lsb;

    // Lookup and training both read the current contents, so same-index updates land next cycle.
    assign lk_idx      = pc_q[IDX+1:2];
    assign lk_tag      = pc_q[31:IDX+2];
    assign lk_hit      = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ent_ctr[lk_idx][1];
    assign pred_target = lk_hit ? ent_target[lk_idx] : 32'h0;
    assign pc_plus4    = pc_q + 32'd4;

    assign up_idx        = bus.update_pc[IDX+1:2];
    assign up_tag        = bus.update_pc[31:IDX+2];
    assign up_hit        = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
    assign unused_up_lsb = ^bus.update_pc[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            logic            valid_q;
            logic [TAGW-1:0] tag_q;
            logic [31:0]     target_q;
            logic [1:0]      ctr_q;
            logic            sel;

            assign sel = bus.update_en && (up_idx == IDX'(gi));

            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    valid_q <= 1'b0;
                    ctr_q   <= 2'b01;
                end else if (sel) begin
                    if (up_hit) begin
                        if (bus.update_taken) begin
                            if (ctr_q != 2'b11) ctr_q <= ctr_q + 2'd1;
                            target_q <= bus.update_target;
                        end else if (ctr_q != 2'b00) begin
                            ctr_q <= ctr_q - 2'd1;
                        end
                    end else if (bus.update_taken) begin
                        valid_q  <= 1'b1;
                        tag_q    <= up_tag;
                        target_q <= bus.update_target;
                        ctr_q    <= 2'b10;
                    end
                end
            end

            assign ent_valid[gi]  = valid_q;
            assign ent_tag[gi]    = tag_q;
            assign ent_target[gi] = target_q;
            assign ent_ctr[gi]    = ctr_q;
        end
    endgenerate

    // Flush outranks halt and stall; halted is sticky until reset.
    always_comb begin
        pc_d     = pc_q;
        fetch_d  = fetch_q;
        halted_d = halted_q;
        if (bus.flush) begin
            pc_d    = bus.correct_pc;
            fetch_d = '0;
        end else if (bus.halt || halted_q) begin
            halted_d = 1'b1;
        end else if (bus.stall) begin
            fetch_d = fetch_q;
        end else if (bus.ihit) begin
            fetch_d = {bus.imemload, pc_plus4, pc_q, pred_taken, pred_target};
            pc_d    = pred_taken ? pred_target : pc_plus4;
        end else begin
            fetch_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc_q     <= PC_INIT;
            fetch_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            fetch_q  <= fetch_d;
            halted_q <= halted_d;
        end
    end

    assign bus.iREN      = nRST && !halted_q;
    assign bus.imemaddr  = pc_q;
    assign bus.fetch_out = fetch_q;
endmodule

// File: tb/tb_fetch_predict_stage.sv
// Randomized bench for fetch_predict_stage: a queue-and-array reference model predicts each
// cycle's outputs into a scoreboard that a separate monitor drains after every clock edge.
module tb_fetch_predict_stage;
    localparam int          N       = 16;
    localparam int          IDX     = $clog2(N);
    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic clk;
    logic nrst;
    fetch_predict_stage_if bus();

    fetch_predict_stage #(.BTB_ENTRIES(N), .PC_INIT(PC_INIT)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [128:0] fo;
        logic [31:0]  pc;
        logic         iren;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference state
    logic [31:0]  m_pc;
    logic [128:0] m_fo;
    bit           m_halted;
    bit           mb_valid  [N];
    logic [31:0]  mb_tag    [N];
    logic [31:0]  mb_target [N];
    int           mb_ctr    [N];

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_step(input bit nr, input bit ih, input logic [31:0] ml, input bit st,
                              input bit fl, input logic [31:0] cpc, input bit ue,
                              input logic [31:0] upc, input logic [31:0] utg, input bit ut,
                              input bit hl);
        int          li, ui;
        bit          lhit, ptk;
        logic [31:0] ptgt;
        exp_t        e;
        if (!nr) begin
            m_pc = PC_INIT; m_fo = '0; m_halted = 0;
            for (int i = 0; i < N; i++) begin mb_valid[i] = 0; mb_ctr[i] = 1; end
        end else begin
            li   = int'((m_pc >> 2) % N);
            lhit = mb_valid[li] && (mb_tag[li] == (m_pc >> (IDX + 2)));
            ptk  = lhit && (mb_ctr[li] >= 2);
            ptgt = lhit ? mb_target[li] : 32'h0;
            if (fl) begin
                m_pc = cpc; m_fo = '0;
            end else if (hl || m_halted) begin
                m_halted = 1;
            end else if (st) begin
                m_fo = m_fo;
            end else if (ih) begin
                m_fo = {ml, m_pc + 32'd4, m_pc, ptk, ptgt};
                m_pc = ptk ? ptgt : m_pc + 32'd4;
            end else begin
                m_fo = '0;
            end
            if (ue) begin
                ui = int'((upc >> 2) % N);
                if (mb_valid[ui] && mb_tag[ui] == (upc >> (IDX + 2))) begin
                    if (ut) begin
                        mb_ctr[ui]    = (mb_ctr[ui] < 3) ? mb_ctr[ui] + 1 : 3;
                        mb_target[ui] = utg;
                    end else begin
                        mb_ctr[ui] = (mb_ctr[ui] > 0) ? mb_ctr[ui] - 1 : 0;
                    end
                end else if (ut) begin
                    mb_valid[ui] = 1; mb_tag[ui] = upc >> (IDX + 2);
                    mb_target[ui] = utg; mb_ctr[ui] = 2;
                end
            end
        end
        e.fo = m_fo; e.pc = m_pc; e.iren = nr && !m_halted;
        exp_q.push_back(e);
    endtask

    // Drive one cycle from the negedge, record the expectation, return at the next negedge.
    task automatic step(input bit nr, input bit ih, input logic [31:0] ml, input bit st,
                        input bit fl, input logic [31:0] cpc, input bit ue,
                        input logic [31:0] upc, input logic [31:0] utg, input bit ut,
                        input bit hl);
        nrst = nr; bus.ihit = ih; bus.imemload = ml; bus.stall = st; bus.flush = fl;
        bus.correct_pc = cpc; bus.update_en = ue; bus.update_pc = upc;
        bus.update_target = utg; bus.update_taken = ut; bus.halt = hl;
        model_step(nr, ih, ml, st, fl, cpc, ue, upc, utg, ut, hl);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_upd(input logic [31:0] upc, input logic [31:0] utg, input bit ut);
        step(1, 0, 0, 0, 0, 0, 1, upc, utg, ut, 0);
    endtask

    task automatic fetch1();
        step(1, 1, 32'h2001_0005, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input logic [31:0] t);
        step(1, 0, 0, 0, 1, t, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fetch_out", bus.fetch_out, e.fo);
            chk("imemaddr", 129'(bus.imemaddr), 129'(e.pc));
            chk("iREN", 129'(bus.iREN), 129'(e.iren));
        end
    end

    initial begin
        @(negedge clk);
        // Reset and sequential fetch
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'h10, 32'h40, 1, 0);
        chk("rst_pc", 129'(bus.imemaddr), 129'(PC_INIT));
        chk("rst_iren", 129'(bus.iREN), 129'(0));
        chk("rst_fo", bus.fetch_out, '0);
        fetch1();
        chk("seq_PC", 129'(bus.fetch_out[64:33]), 129'(32'h0));
        chk("seq_NPC", 129'(bus.fetch_out[96:65]), 129'(32'h4));
        chk("seq_bt", 129'(bus.fetch_out[32]), 129'(0));
        fetch1();
        chk("seq_pc8", 129'(bus.imemaddr), 129'(32'h8));
        // Allocate then predict
        idle_upd(32'h10, 32'h40, 1);
        fetch1(); fetch1(); fetch1();
        chk("pred_bt", 129'(bus.fetch_out[32]), 129'(1));
        chk("pred_tgt", 129'(bus.fetch_out[31:0]), 129'(32'h40));
        chk("pred_npc", 129'(bus.imemaddr), 129'(32'h40));
        // Saturation: three taken, one not-taken still predicts taken
        for (int i = 0; i < 3; i++) idle_upd(32'h10, 32'h40, 1);
        idle_upd(32'h10, 32'h40, 0);
        redirect(32'h10); fetch1();
        chk("sat_taken", 129'(bus.imemaddr), 129'(32'h40));
        idle_upd(32'h10, 32'h40, 0);
        redirect(32'h10); fetch1();
        chk("sat_nt", 129'(bus.imemaddr), 129'(32'h14));
        // Flush beats stall and ihit
        step(1, 1, 32'h1234_5678, 1, 1, 32'h200, 0, 0, 0, 0, 0);
        chk("flush_pc", 129'(bus.imemaddr), 129'(32'h200));
        chk("flush_fo", bus.fetch_out, '0);
        fetch1();
        for (int i = 0; i < 3; i++) step(1, 1, 32'hCAFE_0000, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_pc", 129'(bus.imemaddr), 129'(32'h204));
        chk("stall_fo_PC", 129'(bus.fetch_out[64:33]), 129'(32'h200));
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("nohit_fo", bus.fetch_out, '0);
        chk("nohit_pc", 129'(bus.imemaddr), 129'(32'h204));
        // Halt then reset pulse
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("halt_iren", 129'(bus.iREN), 129'(0));
        fetch1();
        chk("halt_pc", 129'(bus.imemaddr), 129'(32'h204));
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst2_pc", 129'(bus.imemaddr), 129'(PC_INIT));
        chk("rst2_iren", 129'(bus.iREN), 129'(1));
        redirect(32'h10); fetch1();
        chk("rst2_btb", 129'(bus.imemaddr), 129'(32'h14));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit          nr, ih, st, fl, ue, ut, hl;
            logic [31:0] cpc, upc, utg, ml;
            nr  = ($urandom_range(0, 199) != 0);
            ih  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            cpc = 32'($urandom_range(0, 63)) * 32'd4;
            ue  = ($urandom_range(0, 2) == 0);
            upc = 32'($urandom_range(0, 31)) * 32'd4 + (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
            utg = 32'($urandom_range(0, 63)) * 32'd4;
            ut  = ($urandom_range(0, 1) == 1);
            hl  = !fl && ($urandom_range(0, 299) == 0);
            ml  = $urandom;
            step(nr, ih, ml, st, fl, cpc, ue, upc, utg, ut, hl);
        end

        if (exp_q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
